// File: rtl/mips_core_pkg.sv
// Types and helpers shared by the core's shared-resource arbitration logic.
package mips_core_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // Index width for n entries; never narrower than one bit.
    function automatic int unsigned ARB_IDX_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Masked round-robin first-one finder: lowest set bit of (req & ~mask) at or after rr_ptr,
// wrapping; scans a doubled request vector so the wrap needs no modulo logic.
module rr_pick
    import mips_core_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W = ARB_IDX_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_index
);

    localparam int unsigned DBL_W = 2 * NUM_REQ;
    localparam int unsigned POS_W = $clog2(DBL_W);

    logic [NUM_REQ-1:0] w_eff;
    logic [DBL_W-1:0]   w_dbl;
    logic [POS_W-1:0]   w_pos;

    assign w_eff = i_req & ~i_mask;
    assign w_dbl = {w_eff, w_eff};

    // Scan from far to near so the last hit written is the closest to rr_ptr.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        w_pos   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_pos = POS_W'(i_rr_ptr) + POS_W'(i);
            if (w_dbl[w_pos]) begin
                o_valid = 1'b1;
                o_index = (w_pos >= POS_W'(NUM_REQ)) ? IDX_W'(w_pos - POS_W'(NUM_REQ))
                                                     : IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin owner sequencing for one shared resource: grant held until done or request drop,
// with a hold watchdog that force-releases a stuck owner.
module rr_resource_arbiter
    import mips_core_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 64,
    localparam int unsigned IDX_W   = ARB_IDX_W(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_done,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_grant_valid,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_timeout,
    output logic [IDX_W-1:0]   o_timeout_idx
);

    localparam int unsigned       CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic              WDOG_EN   = (MAX_HOLD != 0);

    arb_state_t         r_state,       w_state_d;
    logic [NUM_REQ-1:0] r_grant,       w_grant_d;
    logic               r_grant_valid, w_grant_valid_d;
    logic [IDX_W-1:0]   r_grant_idx,   w_grant_idx_d;
    logic [IDX_W-1:0]   r_rr_ptr,      w_rr_ptr_d;
    logic [CNT_W-1:0]   r_hold_cnt,    w_hold_cnt_d;
    logic               r_timeout,     w_timeout_d;
    logic [IDX_W-1:0]   r_timeout_idx, w_timeout_idx_d;

    logic               w_owned;
    logic               w_fire;
    logic               w_release;
    logic [IDX_W-1:0]   w_ptr_inc;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [NUM_REQ-1:0] w_pick_mask;
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [NUM_REQ-1:0] w_pick_onehot;

    assign w_owned   = (r_state == ARB_OWNED);
    assign w_fire    = WDOG_EN && w_owned && (r_hold_cnt == HOLD_LAST) && !i_done
                       && i_req[r_grant_idx];
    assign w_release = w_owned && (i_done || !i_req[r_grant_idx] || w_fire);
    assign w_ptr_inc = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + 1'b1;

    // On release the search starts past the owner and excludes it, so it cannot be regranted at once.
    assign w_pick_ptr  = w_owned ? w_ptr_inc : r_rr_ptr;
    assign w_pick_mask = w_owned ? r_grant : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_mask   (w_pick_mask),
        .i_rr_ptr (w_pick_ptr),
        .o_valid  (w_pick_valid),
        .o_index  (w_pick_idx)
    );

    assign w_pick_onehot = NUM_REQ'(1) << w_pick_idx;

    always_comb begin
        w_state_d       = r_state;
        w_grant_d       = r_grant;
        w_grant_idx_d   = r_grant_idx;
        w_rr_ptr_d      = r_rr_ptr;
        w_hold_cnt_d    = r_hold_cnt;
        w_timeout_d     = w_fire;
        w_timeout_idx_d = w_fire ? r_grant_idx : r_timeout_idx;

        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_d     = ARB_OWNED;
                    w_grant_d     = w_pick_onehot;
                    w_grant_idx_d = w_pick_idx;
                    w_hold_cnt_d  = '0;
                end
            end
            ARB_OWNED: begin
                if (w_release) begin
                    w_rr_ptr_d   = w_ptr_inc;
                    w_hold_cnt_d = '0;
                    if (w_pick_valid) begin
                        w_grant_d     = w_pick_onehot;
                        w_grant_idx_d = w_pick_idx;
                    end else begin
                        w_state_d     = ARB_IDLE;
                        w_grant_d     = '0;
                        w_grant_idx_d = '0;
                    end
                end else if (r_hold_cnt != '1) begin
                    w_hold_cnt_d = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d     = ARB_IDLE;
                w_grant_d     = '0;
                w_grant_idx_d = '0;
            end
        endcase

        w_grant_valid_d = (w_state_d == ARB_OWNED);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ARB_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_rr_ptr      <= '0;
            r_hold_cnt    <= '0;
            r_timeout     <= 1'b0;
            r_timeout_idx <= '0;
        end else begin
            r_state       <= w_state_d;
            r_grant       <= w_grant_d;
            r_grant_valid <= w_grant_valid_d;
            r_grant_idx   <= w_grant_idx_d;
            r_rr_ptr      <= w_rr_ptr_d;
            r_hold_cnt    <= w_hold_cnt_d;
            r_timeout     <= w_timeout_d;
            r_timeout_idx <= w_timeout_idx_d;
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_idx   = r_grant_idx;
    assign o_timeout     = r_timeout;
    assign o_timeout_idx = r_timeout_idx;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Bench for rr_resource_arbiter: directed vector table plus a random soak against an
// ownership-level reference model.
module tb_rr_resource_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         timeout;
    logic [1:0]   timeout_idx;

    int n_chk  = 0;
    int n_fail = 0;

    rr_resource_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_done        (done),
        .o_grant       (grant),
        .o_grant_valid (grant_valid),
        .o_grant_idx   (grant_idx),
        .o_timeout     (timeout),
        .o_timeout_idx (timeout_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how many cycles, and where the search starts.
    int m_owner   = -1;
    int m_ptr     = 0;
    int m_age     = 0;
    bit m_tmo     = 1'b0;
    int m_tmo_idx = 0;

    function automatic int pick(input logic [N-1:0] r, input int start, input int skip);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_age = 0; m_tmo = 1'b0; m_tmo_idx = 0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                int nxt;
                nxt = pick(req, m_ptr, -1);
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_age   = 1;
                end
            end else begin
                bit fire;
                fire = (MAX_HOLD != 0) && (m_age >= MAX_HOLD) && !done && req[m_owner];
                if (done || !req[m_owner] || fire) begin
                    if (fire) begin
                        m_tmo     = 1'b1;
                        m_tmo_idx = m_owner;
                    end
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = pick(req, m_ptr, m_owner);
                    m_age   = 1;
                end else begin
                    m_age++;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        chk("model_grant", int'(grant), int'(eg));
        chk("model_valid", int'(grant_valid), int'(m_owner >= 0));
        if (m_owner >= 0) chk("model_idx", int'(grant_idx), m_owner);
        chk("model_timeout", int'(timeout), int'(m_tmo));
        if (m_tmo) chk("model_timeout_idx", int'(timeout_idx), m_tmo_idx);
        chk("onehot0", int'($onehot0(grant)), 1);
        chk("valid_vs_grant", int'(grant_valid), int'(|grant));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] grant;
        logic         valid;
        logic [1:0]   idx;
        logic         tmo;
        logic [1:0]   tidx;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [N-1:0] q, input logic d,
                                input logic [N-1:0] g, input logic v, input logic [1:0] i,
                                input logic t, input logic [1:0] ti);
        vec_t e;
        e.rst = r; e.req = q; e.done = d; e.grant = g; e.valid = v; e.idx = i;
        e.tmo = t; e.tidx = ti;
        vecs.push_back(e);
    endfunction

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;

        // Reset, first grant, back-to-back handoff.
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b1010, 0, 4'b0010, 1, 1, 0, 0);
        add(0, 4'b1010, 1, 4'b1000, 1, 3, 0, 0);
        add(0, 4'b1010, 1, 4'b0010, 1, 1, 0, 0);
        // Reset while owned with done high, then full rotation.
        add(1, 4'b1111, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 1, 0, 0, 0);
        add(0, 4'b1111, 1, 4'b0010, 1, 1, 0, 0);
        add(0, 4'b1111, 1, 4'b0100, 1, 2, 0, 0);
        add(0, 4'b1111, 1, 4'b1000, 1, 3, 0, 0);
        add(0, 4'b1111, 1, 4'b0001, 1, 0, 0, 0);
        add(0, 4'b1111, 1, 4'b0010, 1, 1, 0, 0);
        // Owner 1 drops its request: search resumes at 2.
        add(0, 4'b1101, 0, 4'b0100, 1, 2, 0, 0);
        // Owner 2 alone, done on the fifth cycle, idle, then regranted.
        for (int k = 0; k < 4; k++) add(0, 4'b0100, 0, 4'b0100, 1, 2, 0, 0);
        add(0, 4'b0100, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 1, 2, 0, 0);
        // Owner 3 never finishes: watchdog hands over to pending requester 0.
        add(0, 4'b1000, 1, 4'b1000, 1, 3, 0, 0);
        for (int k = 0; k < 7; k++) add(0, 4'b1001, 0, 4'b1000, 1, 3, 0, 0);
        add(0, 4'b1001, 0, 4'b0001, 1, 0, 1, 3);
        // Done at the watchdog limit wins: no pulse.
        for (int k = 0; k < 7; k++) add(0, 4'b1001, 0, 4'b0001, 1, 0, 0, 3);
        add(0, 4'b1001, 1, 4'b1000, 1, 3, 0, 3);
        // Done while idle is ignored.
        add(1, 4'b1001, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0100, 1, 4'b0100, 1, 2, 0, 0);

        for (int v = 0; v < vecs.size(); v++) begin
            rst  = vecs[v].rst;
            req  = vecs[v].req;
            done = vecs[v].done;
            tick();
            chk($sformatf("vec%0d_grant", v), int'(grant), int'(vecs[v].grant));
            chk($sformatf("vec%0d_valid", v), int'(grant_valid), int'(vecs[v].valid));
            if (vecs[v].valid) chk($sformatf("vec%0d_idx", v), int'(grant_idx), int'(vecs[v].idx));
            chk($sformatf("vec%0d_timeout", v), int'(timeout), int'(vecs[v].tmo));
            chk($sformatf("vec%0d_timeout_idx", v), int'(timeout_idx), int'(vecs[v].tidx));
        end

        // Random soak: requests change occasionally so owners linger and the watchdog fires.
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
